// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two-requester round-robin arbiter feeding one UART transmitter
// Optional WAIT-state watchdog compiled in with `define ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int          N       = 8,
    parameter logic [31:0] TIMEOUT = 32'd200000
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic         req0_valid_i,
    input  logic [N-1:0] req0_data_i,
    output logic         req0_ready_o,
    input  logic         req1_valid_i,
    input  logic [N-1:0] req1_data_i,
    output logic         req1_ready_o,
    output logic         tx_start_o,
    output logic [N-1:0] tx_data_o,
    input  logic         tx_end_i,
    output logic         busy_o,
    output logic         grant_o,
    output logic         timeout_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]   state_q, state_d;
    logic         full0_q, full0_d, full1_q, full1_d;
    logic         rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic [N-1:0] data0_q, data0_d, data1_q, data1_d;
    logic [N-1:0] tx_data_q, tx_data_d;
    logic         grant_q, grant_d;
    logic         pick;
`ifdef ARB_TIMEOUT_EN
    logic [31:0]  cnt_q, cnt_d;
    logic         expire;

    // tx_end_i on the expiry cycle wins, so the pulse is suppressed then
    assign expire = (state_q == S_WAIT) && !tx_end_i && (cnt_q == TIMEOUT - 32'd1);
`endif

    always_comb begin
        state_d   = state_q;
        full0_d   = full0_q;
        full1_d   = full1_q;
        data0_d   = data0_q;
        data1_d   = data1_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        pick      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        if (req0_valid_i && rdy0_q) begin
            full0_d = 1'b1;
            data0_d = req0_data_i;
        end
        if (req1_valid_i && rdy1_q) begin
            full1_d = 1'b1;
            data1_d = req1_data_i;
        end
        case (state_q)
            S_IDLE: begin
                if (full0_q || full1_q) begin
                    // on a tie the requester that did not own the last transfer wins
                    pick      = (full0_q && full1_q) ? ~grant_q : full1_q;
                    grant_d   = pick;
                    tx_data_d = pick ? data1_q : data0_q;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (grant_q) full1_d = 1'b0;
                else         full0_d = 1'b0;
                state_d = S_WAIT;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = 32'd0;
`endif
            end
            S_WAIT: begin
                if (tx_end_i) begin
                    state_d = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (expire) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        rdy0_d = ~full0_d;
        rdy1_d = ~full1_d;
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            full0_q   <= 1'b0;
            full1_q   <= 1'b0;
            rdy0_q    <= 1'b1;
            rdy1_q    <= 1'b1;
            data0_q   <= '0;
            data1_q   <= '0;
            tx_data_q <= '0;
            grant_q   <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            full0_q   <= full0_d;
            full1_q   <= full1_d;
            rdy0_q    <= rdy0_d;
            rdy1_q    <= rdy1_d;
            data0_q   <= data0_d;
            data1_q   <= data1_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign req0_ready_o = rdy0_q;
    assign req1_ready_o = rdy1_q;
    assign tx_start_o   = (state_q == S_START);
    assign tx_data_o    = tx_data_q;
    assign busy_o       = (state_q != S_IDLE);
    assign grant_o      = grant_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_o    = expire;
`else
    assign timeout_o    = 1'b0;
`endif

endmodule
